// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition front end: FSM encoding, default widths
// and a constant-foldable ceil(log2) used to size counters.
package acq_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StScan    = 3'd1,
        StWait    = 3'd2,
        StPresent = 3'd3,
        StDone    = 3'd4
    } acq_state_e;

    localparam int unsigned AcqNumCh = 4;
    localparam int unsigned AcqDataW = 2;

    // Never returns less than 1 so single-entry counters still get a bit.
    function automatic int unsigned clog2(input int unsigned val);
        int unsigned res;
        longint unsigned pow;
        res = 0;
        pow = 1;
        while (pow < longint'(val)) begin
            pow = pow << 1;
            res++;
        end
        return (res == 0) ? 1 : res;
    endfunction

endpackage

// File: rtl/acq_sequencer_if.sv
// Sample output port of the acquisition sequencer: valid/ready handshake carrying
// the captured register value and its channel tag.
interface acq_sequencer_if
    import acq_pkg::*;
#(
    parameter int unsigned NUM_CH = AcqNumCh,
    parameter int unsigned DATA_W = AcqDataW
) ();

    localparam int unsigned CH_W = clog2(NUM_CH);

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CH_W-1:0]   out_ch;

    modport master (
        output out_valid,
        output out_data,
        output out_ch,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_ch,
        output out_ready
    );

endinterface

// File: rtl/acq_settle_timer.sv
// Loadable down-counter timing the settle window between a register load strobe
// and sampling that register's output.
module acq_settle_timer
    import acq_pkg::*;
#(
    parameter int unsigned SETTLE = 3
) (
    input  logic new_clk,
    input  logic reset_n,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int unsigned CNT_W = clog2(SETTLE + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(SETTLE);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Flags the decrement that lands on zero, so the caller acts on that same edge.
    assign zero = dec && (cnt_q == CNT_W'(1));

    always_ff @(posedge new_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/acq_sequencer.sv
// Frame sequencer: strobes each enabled channel register in ascending order, waits
// the settle time, then offers the captured sample on a valid/ready port.
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int unsigned NUM_CH = AcqNumCh,
    parameter int unsigned DATA_W = AcqDataW,
    parameter int unsigned SETTLE = 3
) (
    input  logic                     new_clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic [NUM_CH*DATA_W-1:0] reg_q,
    output logic [NUM_CH-1:0]        reg_en,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overrun,
    input  logic                     clr_ovr,
    acq_sequencer_if.master          out_if
);

    localparam int unsigned CH_W = clog2(NUM_CH);

    acq_state_e        state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic              ovr_q, ovr_d;

    logic accept;
    logic ch_en;
    logic ch_last;
    logic ch_inc;
    logic capture;
    logic valid;
    logic tmr_load;
    logic tmr_dec;
    logic tmr_zero;

    assign accept  = (state_q == StIdle) && start && (ch_mask != '0);
    assign ch_en   = mask_q[ch_q];
    assign ch_last = (ch_q == CH_W'(NUM_CH - 1));

    acq_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .new_clk (new_clk),
        .reset_n (reset_n),
        .load    (tmr_load),
        .dec     (tmr_dec),
        .zero    (tmr_zero)
    );

    always_ff @(posedge new_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StScan;
                end
            end
            StScan: begin
                if (ch_en) begin
                    state_d = StWait;
                end else if (ch_last) begin
                    state_d = StDone;
                end
            end
            StWait: begin
                if (tmr_zero) begin
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (out_if.out_ready) begin
                    state_d = ch_last ? StDone : StScan;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // reg_en is a pure decode of state, so reset clears an in-flight strobe at once.
    always_comb begin
        reg_en     = '0;
        busy       = 1'b1;
        frame_done = 1'b0;
        valid      = 1'b0;
        tmr_load   = 1'b0;
        tmr_dec    = 1'b0;
        capture    = 1'b0;
        ch_inc     = 1'b0;
        unique case (state_q)
            StIdle: busy = 1'b0;
            StScan: begin
                if (ch_en) begin
                    reg_en[ch_q] = 1'b1;
                    tmr_load     = 1'b1;
                end else begin
                    ch_inc = !ch_last;
                end
            end
            StWait: begin
                tmr_dec = 1'b1;
                capture = tmr_zero;
            end
            StPresent: begin
                valid  = 1'b1;
                ch_inc = out_if.out_ready && !ch_last;
            end
            StDone:  frame_done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    always_comb begin
        ch_d       = ch_q;
        mask_d     = mask_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        ovr_d      = ovr_q;
        if (accept) begin
            ch_d   = '0;
            mask_d = ch_mask;
        end else if (ch_inc) begin
            ch_d = ch_q + 1'b1;
        end
        if (capture) begin
            out_data_d = reg_q[int'(ch_q) * int'(DATA_W) +: DATA_W];
            out_ch_d   = ch_q;
        end
        // Set has priority over clear when both land in the same cycle.
        if (clr_ovr) begin
            ovr_d = 1'b0;
        end
        if (start && (state_q != StIdle)) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge new_clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_q       <= '0;
            mask_q     <= '0;
            out_data_q <= '0;
            out_ch_q   <= '0;
            ovr_q      <= 1'b0;
        end else begin
            ch_q       <= ch_d;
            mask_q     <= mask_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            ovr_q      <= ovr_d;
        end
    end

    assign out_if.out_valid = valid;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_ch    = out_ch_q;
    assign overrun          = ovr_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Randomised bench for acq_sequencer: a per-frame timeline model built from the
// channel cost rules is compared against the DUT outputs every cycle.
module tb_acq_sequencer;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 2;
    localparam int SETTLE = 3;
    localparam int MAXC   = 16384;
    localparam int FILL   = 400;

    logic       new_clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       start   = 1'b0;
    logic       clr_ovr = 1'b0;
    logic [3:0] ch_mask = '0;
    logic [7:0] reg_q   = '0;
    logic [3:0] reg_en;
    logic       busy;
    logic       frame_done;
    logic       overrun;

    acq_sequencer_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    acq_sequencer #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .SETTLE (SETTLE)
    ) dut (
        .new_clk    (new_clk),
        .reset_n    (reset_n),
        .start      (start),
        .ch_mask    (ch_mask),
        .reg_q      (reg_q),
        .reg_en     (reg_en),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun),
        .clr_ovr    (clr_ovr),
        .out_if     (bus)
    );

    always #5 new_clk = ~new_clk;

    int cyc = 0;
    always @(posedge new_clk) cyc <= cyc + 1;

    // Expected timeline, indexed by cycle number.
    bit       exp_valid [MAXC];
    bit       exp_busy  [MAXC];
    bit       exp_done  [MAXC];
    bit [3:0] exp_en    [MAXC];
    bit [1:0] exp_ch    [MAXC];
    bit [1:0] exp_data  [MAXC];
    bit       ready_arr [MAXC];

    int n_cmp = 0;
    int n_err = 0;
    int hs_cnt = 0;
    int en_cnt = 0;
    bit chk_en = 1'b0;
    bit ovr_model = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Enabled channel: 1 scan + SETTLE wait + present until ready; masked: 1 cycle.
    function automatic int plan_frame(input int s, input bit [3:0] m, input bit [7:0] rq);
        int t;
        int v;
        int h;
        t = s + 1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (m[ch]) begin
                exp_en[t] = 4'(1 << ch);
                v = t + 1 + SETTLE;
                h = v;
                while (!ready_arr[h] && (h < s + FILL - 1)) h++;
                ready_arr[h] = 1'b1;
                for (int c = v; c <= h; c++) begin
                    exp_valid[c] = 1'b1;
                    exp_ch[c]    = 2'(ch);
                    exp_data[c]  = rq[ch*2 +: 2];
                end
                t = h + 1;
            end else begin
                t++;
            end
        end
        exp_done[t] = 1'b1;
        for (int c = s + 1; c <= t; c++) exp_busy[c] = 1'b1;
        return t;
    endfunction

    function automatic void clear_plan(input int a, input int b);
        for (int c = a; c <= b; c++) begin
            exp_valid[c] = 1'b0;
            exp_busy[c]  = 1'b0;
            exp_done[c]  = 1'b0;
            exp_en[c]    = '0;
            exp_ch[c]    = '0;
            exp_data[c]  = '0;
        end
    endfunction

    function automatic void fill_ready(input int s, input int mode);
        for (int c = s; c < s + FILL; c++) begin
            case (mode)
                0:       ready_arr[c] = 1'b1;
                1:       ready_arr[c] = ($urandom_range(0, 2) != 0);
                default: ready_arr[c] = (c >= s + 2 + SETTLE + 7);
            endcase
        end
    endfunction

    // Advance one cycle; overrun model follows the inputs seen in the cycle just ended.
    task automatic tick();
        bit nxt;
        if (start && exp_busy[cyc]) nxt = 1'b1;
        else if (clr_ovr)           nxt = 1'b0;
        else                        nxt = ovr_model;
        @(posedge new_clk);
        ovr_model = nxt;
        #1;
        bus.out_ready = ready_arr[cyc];
    endtask

    always @(negedge new_clk) begin
        if (chk_en) begin
            check_eq("reg_en", 32'(reg_en), 32'(exp_en[cyc]));
            check_eq("out_valid", 32'(bus.out_valid), 32'(exp_valid[cyc]));
            check_eq("busy", 32'(busy), 32'(exp_busy[cyc]));
            check_eq("frame_done", 32'(frame_done), 32'(exp_done[cyc]));
            check_eq("overrun", 32'(overrun), 32'(ovr_model));
            if (exp_valid[cyc]) begin
                check_eq("out_ch", 32'(bus.out_ch), 32'(exp_ch[cyc]));
                check_eq("out_data", 32'(bus.out_data), 32'(exp_data[cyc]));
            end
        end
        if (bus.out_valid && bus.out_ready) hs_cnt++;
        if (reg_en != '0) en_cnt++;
    end

    task automatic run_frame(input bit [3:0] m, input bit [7:0] rq, input int mode,
                             input int poff, input bit pclr);
        int s;
        int done;
        int hs0;
        int en0;
        s = cyc;
        fill_ready(s, mode);
        ch_mask = m;
        reg_q   = rq;
        start   = 1'b1;
        done = (m != '0) ? plan_frame(s, m, rq) : s;
        hs0 = hs_cnt;
        en0 = en_cnt;
        tick();
        start   = 1'b0;
        ch_mask = 4'($urandom);
        while (cyc <= done) begin
            if ((poff > 0) && (cyc == s + poff)) begin
                start   = 1'b1;
                clr_ovr = pclr;
            end
            tick();
            start   = 1'b0;
            clr_ovr = 1'b0;
        end
        check_eq("hs_count", 32'(hs_cnt - hs0), 32'($countones(m)));
        check_eq("en_count", 32'(en_cnt - en0), 32'($countones(m)));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_reg_en"}, 32'(reg_en), 32'd0);
        check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check_eq({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
        check_eq({tag, "_out_ch"}, 32'(bus.out_ch), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check_eq({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        int done;
        bus.out_ready = 1'b0;
        #1 reset_n = 1'b0;
        #1 check_all_zero("por");
        tick();
        tick();
        reset_n = 1'b1;
        chk_en  = 1'b1;
        tick();

        run_frame(4'b1111, 8'b11_10_01_00, 0, 0, 1'b0);
        run_frame(4'b1010, 8'($urandom), 0, 0, 1'b0);
        run_frame(4'b1111, 8'($urandom), 2, 0, 1'b0);

        run_frame(4'b0110, 8'($urandom), 1, 3, 1'b0);
        run_frame(4'b1001, 8'($urandom), 0, 4, 1'b1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        tick();
        // Mask 0001 with all-ready: DONE falls at start+9, so this start hits DONE.
        run_frame(4'b0001, 8'($urandom), 0, 9, 1'b0);
        run_frame(4'b1100, 8'($urandom), 0, 0, 1'b0);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;

        run_frame(4'b0000, 8'($urandom), 0, 0, 1'b0);
        tick();
        tick();

        // Abort a frame during the settle wait of channel 2.
        s = cyc;
        fill_ready(s, 0);
        ch_mask = 4'hF;
        reg_q   = 8'($urandom_range(1, 255));
        start   = 1'b1;
        done = plan_frame(s, ch_mask, reg_q);
        tick();
        start = 1'b0;
        while (cyc < s + 3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < s + 13) tick();
        @(negedge new_clk);
        #2;
        chk_en  = 1'b0;
        reset_n = 1'b0;
        #1 check_all_zero("mid_rst");
        ovr_model = 1'b0;
        clear_plan(s, done);
        tick();
        tick();
        reset_n = 1'b1;
        chk_en  = 1'b1;
        tick();
        run_frame(4'b1111, 8'($urandom), 1, 0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            run_frame(4'($urandom), 8'($urandom), $urandom_range(0, 2),
                      ($urandom_range(0, 1) != 0) ? $urandom_range(1, 20) : 0,
                      1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                clr_ovr = 1'b1;
                tick();
                clr_ovr = 1'b0;
            end
        end
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
